// File: rtl/ej32_div_seq.sv
// ---------------------------------------------------------------------------
// ej32_div_seq -- sequential radix-2 signed divider for eJ32 idiv/irem
//
// Produces quotient and remainder with Java semantics (truncate toward zero,
// remainder takes the sign of the dividend). The core is a non-restoring
// magnitude divider. A final FIX cycle applies the remainder correction and
// the sign fix-up.
//
// Ports:
//   clk    in   1    system clock, all state changes on posedge
//   rst    in   1    synchronous reset, active-high
//   start  in   1    launch a division (sampled only when busy=0)
//   x      in   DSZ  signed dividend, captured on accepted start
//   y      in   DSZ  signed divisor, captured on accepted start
//   busy   out  1    operation in progress, start ignored while high
//   done   out  1    one-cycle pulse; q, r and z are valid from this cycle on
//   z      out  1    divide-by-zero flag of the last completed operation
//   q      out  DSZ  signed quotient, held until the next completion
//   r      out  DSZ  signed remainder, held likewise
//
// Build option:
//   EJ32_DIV_SKIP_EN -- pre-normalise |x| by its leading-zero count so that
//   only the significant dividend bits are iterated. The results are the same
//   as in the default build; only the latency shrinks. When the macro is
//   undefined, the divider always runs DSZ iterations and no leading-zero
//   counter is built.
// ---------------------------------------------------------------------------
module ej32_div_seq #(
    parameter int DSZ = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [DSZ-1:0] x,
    input  logic [DSZ-1:0] y,
    output logic           busy,
    output logic           done,
    output logic           z,
    output logic [DSZ-1:0] q,
    output logic [DSZ-1:0] r
);

    localparam int CW = $clog2(DSZ) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t         state_reg;
    logic [DSZ-1:0] a_reg;       // dividend bits shifting out, quotient bits shifting in
    logic [DSZ-1:0] d_reg;       // |divisor|
    logic [DSZ:0]   p_reg;       // signed partial remainder
    logic [CW-1:0]  cnt_reg;
    logic           sign_q_reg;
    logic           sign_r_reg;
    logic           busy_reg;
    logic           done_reg;
    logic           z_reg;
    logic [DSZ-1:0] q_reg;
    logic [DSZ-1:0] r_reg;

    // Operand magnitudes. Negating the most negative value wraps to itself.
    // Read as unsigned, that is exactly 2^(DSZ-1).
    logic [DSZ-1:0] x_abs;
    logic [DSZ-1:0] y_abs;
    assign x_abs = x[DSZ-1] ? -x : x;
    assign y_abs = y[DSZ-1] ? -y : y;

    logic [DSZ-1:0] a_init;
    logic [CW-1:0]  cnt_init;

`ifdef EJ32_DIV_SKIP_EN
    // Leading-zero count of |x|. The loop keeps the highest set bit.
    // A zero dividend gives DSZ.
    logic [CW-1:0] lz;
    always_comb begin
        lz = CW'(DSZ);
        for (int i = 0; i < DSZ; i++) begin
            if (x_abs[i]) lz = CW'(DSZ - 1 - i);
        end
    end
    assign a_init   = x_abs << lz;
    // At least one iteration, so a zero dividend still goes through RUN/FIX.
    assign cnt_init = (lz == CW'(DSZ)) ? CW'(1) : (CW'(DSZ) - lz);
`else
    assign a_init   = x_abs;
    assign cnt_init = CW'(DSZ);
`endif

    // One non-restoring step. The partial remainder stays within [-d, d),
    // so dropping its top bit before the shift loses nothing.
    logic [DSZ:0]   d_ext;
    logic [DSZ:0]   p_sh;
    logic [DSZ:0]   p_step;
    logic [DSZ-1:0] a_step;
    logic [DSZ:0]   p_fix;

    assign d_ext  = {1'b0, d_reg};
    assign p_sh   = {p_reg[DSZ-1:0], a_reg[DSZ-1]};
    assign p_step = p_reg[DSZ] ? (p_sh + d_ext) : (p_sh - d_ext);
    assign a_step = {a_reg[DSZ-2:0], ~p_step[DSZ]};
    // A negative final partial remainder is one divisor short.
    assign p_fix  = p_reg[DSZ] ? (p_reg + d_ext) : p_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            d_reg      <= '0;
            p_reg      <= '0;
            cnt_reg    <= '0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            z_reg      <= 1'b0;
            q_reg      <= '0;
            r_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (y == '0) begin
                            // Divide by zero completes immediately with no iterations.
                            done_reg <= 1'b1;
                            z_reg    <= 1'b1;
                            q_reg    <= '0;
                            r_reg    <= x;
                        end else begin
                            sign_q_reg <= x[DSZ-1] ^ y[DSZ-1];
                            sign_r_reg <= x[DSZ-1];
                            a_reg      <= a_init;
                            d_reg      <= y_abs;
                            p_reg      <= '0;
                            cnt_reg    <= cnt_init;
                            busy_reg   <= 1'b1;
                            state_reg  <= RUN;
                        end
                    end
                end
                RUN: begin
                    p_reg   <= p_step;
                    a_reg   <= a_step;
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) state_reg <= FIX;
                end
                FIX: begin
                    q_reg     <= sign_q_reg ? -a_reg : a_reg;
                    r_reg     <= sign_r_reg ? -p_fix[DSZ-1:0] : p_fix[DSZ-1:0];
                    z_reg     <= 1'b0;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign z    = z_reg;
    assign q    = q_reg;
    assign r    = r_reg;

endmodule

// File: tb/tb_ej32_div_seq.sv
// ---------------------------------------------------------------------------
// tb_ej32_div_seq -- directed self-checking bench for ej32_div_seq (DSZ=32)
//
// Cycle numbering: the cycle in which start is sampled is cycle 0. Outputs are
// sampled 1 time unit after each rising edge. Expected latencies depend on
// whether EJ32_DIV_SKIP_EN is defined. The bench defines the expected
// latencies itself for each build.
// ---------------------------------------------------------------------------
module tb_ej32_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        done;
    logic        z;
    logic [31:0] q;
    logic [31:0] r;

    int n_vec = 0;
    int n_err = 0;

`ifdef EJ32_DIV_SKIP_EN
    localparam int L100  = 9;   // |x|=100, clz=25 -> 7 iterations
    localparam int L9    = 6;   // clz(9)=28 -> 4 iterations
    localparam int L7    = 5;   // clz(7)=29 -> 3 iterations
    localparam int L0    = 3;   // x=0 -> 1 iteration
    localparam int LMIN  = 34;  // clz=0
    localparam int LMAXP = 33;  // clz(0x7FFFFFFF)=1
`else
    localparam int L100  = 34;
    localparam int L9    = 34;
    localparam int L7    = 34;
    localparam int L0    = 34;
    localparam int LMIN  = 34;
    localparam int LMAXP = 34;
`endif

    ej32_div_seq #(.DSZ(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .q     (q),
        .r     (r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one division, optionally inject an extra start (50/5) in cycle
    // inj, and wait for done. The wait is bounded. Returns in the done cycle,
    // so the next call's start lands in that done cycle (back-to-back).
    task automatic run_op(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                          input int inj, input logic [31:0] eq, input logic [31:0] er,
                          input logic ez, input int elat);
        logic [31:0] q0;
        int lat;
        int bbad;
        int hbad;
        bbad = 0;
        hbad = 0;
        @(negedge clk);
        q0    = q;
        x     = xv;
        y     = yv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = $urandom;
        y     = $urandom;
        lat   = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) bbad++;
            if (q !== q0) hbad++;
            if (lat == inj) begin
                start = 1'b1;
                x     = 32'd50;
                y     = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, " busy_gaps"}, 32'(bbad), 32'd0);
        chk({tag, " q_held"}, 32'(hbad), 32'd0);
        chk({tag, " q"}, q, eq);
        chk({tag, " r"}, r, er);
        chk({tag, " z"}, 32'(z), 32'(ez));
        $display("op %-10s x=0x%08h y=0x%08h -> q=0x%08h r=0x%08h z=%0d latency=%0d",
                 tag, xv, yv, q, r, z, lat);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset z", 32'(z), 32'd0);
        chk("reset q", q, 32'd0);
        chk("reset r", r, 32'd0);
        rst = 1'b0;

        run_op("100/7",    32'd100,        32'd7,          -1, 32'd14,         32'd2,          1'b0, L100);
        run_op("-100/7",   32'hFFFF_FF9C,  32'd7,          -1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0, L100);
        run_op("100/-7",   32'd100,        32'hFFFF_FFF9,  -1, 32'hFFFF_FFF2,  32'd2,          1'b0, L100);
        run_op("7/0",      32'd7,          32'd0,          -1, 32'd0,          32'd7,          1'b1, 1);
        run_op("-7/-2",    32'hFFFF_FFF9,  32'hFFFF_FFFE,  -1, 32'd3,          32'hFFFF_FFFF,  1'b0, L7);
        run_op("MIN/-1",   32'h8000_0000,  32'hFFFF_FFFF,  -1, 32'h8000_0000,  32'd0,          1'b0, LMIN);
        run_op("MAX/MIN",  32'h7FFF_FFFF,  32'h8000_0000,  -1, 32'd0,          32'h7FFF_FFFF,  1'b0, LMAXP);
        run_op("0/0",      32'd0,          32'd0,          -1, 32'd0,          32'd0,          1'b1, 1);
        run_op("0/5",      32'd0,          32'd5,          -1, 32'd0,          32'd0,          1'b0, L0);
        // The extra start 50/5 in cycle 5 must be ignored.
        run_op("ignore",   32'd100,        32'd7,           5, 32'd14,         32'd2,          1'b0, L100);
        // This start lands in the done cycle of the previous op.
        run_op("b2b 9/2",  32'd9,          32'd2,          -1, 32'd4,          32'd1,          1'b0, L9);
        run_op("100/7 #2", 32'd100,        32'd7,          -1, 32'd14,         32'd2,          1'b0, L100);

        // Reset during an operation (cycle 10).
        @(negedge clk);
        x     = 32'd100;
        y     = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midop q held", q, 32'd14);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst q", q, 32'd0);
        chk("rst r", r, 32'd0);
        $display("op reset mid-operation -> busy=%0d done=%0d q=0x%08h r=0x%08h", busy, done, q, r);

        // Reset has priority over a start in the same cycle.
        rst   = 1'b1;
        start = 1'b1;
        x     = 32'd9;
        y     = 32'd2;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst+start busy", 32'(busy), 32'd0);
        chk("rst+start done", 32'(done), 32'd0);
        $display("op reset with start -> busy=%0d done=%0d", busy, done);

        // The divider must still work normally after reset.
        run_op("post-rst", 32'd9,          32'd2,          -1, 32'd4,          32'd1,          1'b0, L9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
